// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - round-robin arbiter granting one write-enabled register to N requesters
// Optional back-to-back locked writes are compiled in with `define REG_ARB_LOCK_EN.
module reg_write_arbiter #(
    parameter int W        = 4,
    parameter int N        = 4,
    parameter int IW       = 2,
    parameter int MAX_LOCK = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] data_in,
    input  logic [N-1:0]   lock,
    output logic           we,
    output logic [W-1:0]   load,
    output logic [N-1:0]   ack,
    output logic [IW-1:0]  grant_id,
    output logic           busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]       grant_id_q, grant_id_d;
    logic [W-1:0]        load_q, load_d;

    logic [N-1:0][W-1:0] data_arr;
    logic                found;
    logic [IW-1:0]       winner;
    logic [IW:0]         idx;
    logic [IW:0]         next_ptr;

    assign data_arr = data_in;

`ifdef REG_ARB_LOCK_EN
    localparam int LCW = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;
    logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
    logic           hold_lock;

    assign hold_lock = req[grant_id_q] && lock[grant_id_q] &&
                       (lock_cnt_q < LCW'(MAX_LOCK - 1));
`else
    logic unused_cfg;
    assign unused_cfg = ^{lock, MAX_LOCK[0]};
`endif

    // Search starts at rr_ptr so the previous owner is always visited last.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = 0; k < N; k++) begin
            idx = {1'b0, rr_ptr_q} + (IW+1)'(k);
            if (idx >= (IW+1)'(N)) begin
                idx = idx - (IW+1)'(N);
            end
            if (!found && req[idx[IW-1:0]]) begin
                found  = 1'b1;
                winner = idx[IW-1:0];
            end
        end
    end

    always_comb begin
        next_ptr = {1'b0, grant_id_q} + (IW+1)'(1);
        if (next_ptr >= (IW+1)'(N)) begin
            next_ptr = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            load_q     <= '0;
`ifdef REG_ARB_LOCK_EN
            lock_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            load_q     <= load_d;
`ifdef REG_ARB_LOCK_EN
            lock_cnt_q <= lock_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        load_d     = load_q;
`ifdef REG_ARB_LOCK_EN
        lock_cnt_d = lock_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (found) begin
                    load_d     = data_arr[winner];
                    grant_id_d = winner;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
`ifdef REG_ARB_LOCK_EN
                if (hold_lock) begin
                    load_d     = data_arr[grant_id_q];
                    lock_cnt_d = lock_cnt_q + LCW'(1);
                end else begin
                    lock_cnt_d = '0;
                    rr_ptr_d   = next_ptr[IW-1:0];
                    state_d    = IDLE;
                end
`else
                rr_ptr_d = next_ptr[IW-1:0];
                state_d  = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobes decode from registered state only, so they cannot glitch.
    always_comb begin
        we   = 1'b0;
        busy = 1'b0;
        ack  = '0;
        if (state_q == GRANT) begin
            we              = 1'b1;
            busy            = 1'b1;
            ack[grant_id_q] = 1'b1;
        end
    end

    assign load     = load_q;
    assign grant_id = grant_id_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb/tb_reg_write_arbiter.sv - self-checking bench for reg_write_arbiter
module tb_reg_write_arbiter;

    localparam int W  = 4;
    localparam int N  = 4;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N*W-1:0] data_in;
    logic [N-1:0]   lock;
    logic           we;
    logic [W-1:0]   load;
    logic [N-1:0]   ack;
    logic [IW-1:0]  grant_id;
    logic           busy;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [IW-1:0] id;
        logic [W-1:0]  data;
    } wr_t;
    wr_t sb[$];

    typedef struct {
        logic           rst;
        logic [N-1:0]   req;
        logic [N*W-1:0] data;
        logic           exp_we;
        logic [N-1:0]   exp_ack;
        logic [W-1:0]   exp_load;
        logic [IW-1:0]  exp_gid;
    } vec_t;
    vec_t vt[10];

`ifdef REG_ARB_LOCK_EN
    localparam int K6 = 6;
    int we6[K6]  = '{1, 1, 1, 1, 0, 1};
    int id6[K6]  = '{1, 1, 1, 1, 0, 0};
    int dat6[K6] = '{1, 2, 3, 4, 0, 6};
`else
    localparam int K6 = 3;
    int we6[K6]  = '{1, 0, 1};
    int id6[K6]  = '{1, 0, 0};
    int dat6[K6] = '{1, 0, 6};
`endif

    always #5 clk = ~clk;

    reg_write_arbiter #(.W(W), .N(N), .IW(IW), .MAX_LOCK(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .data_in  (data_in),
        .lock     (lock),
        .we       (we),
        .load     (load),
        .ack      (ack),
        .grant_id (grant_id),
        .busy     (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int id, input int data);
        wr_t e;
        e.id   = IW'(id);
        e.data = W'(data);
        sb.push_back(e);
    endtask

    always @(negedge clk) begin : monitor
        wr_t e;
        if (we === 1'b1) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got id %0d data %0h expected no write at %0t",
                         grant_id, load, $time);
            end else begin
                e = sb.pop_front();
                check("sb_grant_id", 32'(grant_id), 32'(e.id));
                check("sb_load",     32'(load),     32'(e.data));
                check("sb_ack",      32'(ack),      32'(1 << e.id));
                check("sb_busy",     32'(busy),     32'd1);
            end
        end
    end

    initial begin
        logic [N-1:0] dropped;

        reset = 1'b1; req = '0; data_in = '0; lock = '0;

        vt[0] = '{1'b1, 4'hF,    16'h0000, 1'b0, 4'b0000, 4'h0, 2'd0};
        vt[1] = '{1'b1, 4'hF,    16'h0000, 1'b0, 4'b0000, 4'h0, 2'd0};
        vt[2] = '{1'b0, 4'b0100, 16'h0A00, 1'b1, 4'b0100, 4'hA, 2'd2};
        vt[3] = '{1'b0, 4'b0000, 16'h0A00, 1'b0, 4'b0000, 4'hA, 2'd2};
        vt[4] = '{1'b0, 4'b0011, 16'h0021, 1'b1, 4'b0001, 4'h1, 2'd0};
        vt[5] = '{1'b0, 4'b0000, 16'h0000, 1'b0, 4'b0000, 4'h1, 2'd0};
        vt[6] = '{1'b0, 4'b1001, 16'hC005, 1'b1, 4'b1000, 4'hC, 2'd3};
        vt[7] = '{1'b0, 4'b0001, 16'hC005, 1'b0, 4'b0000, 4'hC, 2'd3};
        vt[8] = '{1'b0, 4'b0001, 16'hC005, 1'b1, 4'b0001, 4'h5, 2'd0};
        vt[9] = '{1'b0, 4'b0000, 16'h0000, 1'b0, 4'b0000, 4'h5, 2'd0};

        for (int i = 0; i < 10; i++) begin
            reset   = vt[i].rst;
            req     = vt[i].req;
            data_in = vt[i].data;
            if (vt[i].exp_we) push(int'(vt[i].exp_gid), int'(vt[i].exp_load));
            tick;
            check($sformatf("vec%0d_we", i),   32'(we),       32'(vt[i].exp_we));
            check($sformatf("vec%0d_ack", i),  32'(ack),      32'(vt[i].exp_ack));
            check($sformatf("vec%0d_load", i), 32'(load),     32'(vt[i].exp_load));
            check($sformatf("vec%0d_gid", i),  32'(grant_id), 32'(vt[i].exp_gid));
            check($sformatf("vec%0d_busy", i), 32'(busy),     32'(vt[i].exp_we));
        end

        // All four requesting continuously from reset.
        reset = 1'b1; req = '0; tick;
        reset = 1'b0; data_in = 16'h9753; req = 4'hF; dropped = '0;
        push(0, 3); push(1, 5); push(2, 7); push(3, 9); push(0, 3);
        for (int k = 0; k < 10; k++) begin
            tick;
            check("rr_we_cadence", 32'(we), 32'(k % 2 == 0));
            req     = req | dropped;
            dropped = ack;
            req     = req & ~ack;
        end
        req = '0;
        tick;

        // Reset during GRANT drops the write and clears the pointer.
        req = 4'b0100; data_in = 16'h0A00; push(2, 10);
        tick;
        check("pre_reset_we", 32'(we), 32'd1);
        reset = 1'b1; req = '0;
        tick;
        check("midgrant_reset_we",   32'(we),       32'd0);
        check("midgrant_reset_ack",  32'(ack),      32'd0);
        check("midgrant_reset_busy", 32'(busy),     32'd0);
        check("midgrant_reset_gid",  32'(grant_id), 32'd0);
        check("midgrant_reset_load", 32'(load),     32'd0);
        reset = 1'b0; req = 4'b1010; data_in = 16'hE060; push(1, 6);
        tick;
        check("post_reset_rr_gid", 32'(grant_id), 32'd1);
        req = '0;
        tick;

        // Locked owner vs. waiting requester 0.
        req = 4'b0001; data_in = 16'h0006; push(0, 6);
        tick;
        req = '0;
        tick;
        lock = 4'b0010;
        for (int k = 0; k < K6; k++) begin
            req     = 4'b0011;
            data_in = {8'h00, 4'(k + 1), 4'h6};
            if (we6[k] != 0) push(id6[k], dat6[k]);
            tick;
            check($sformatf("lock_step%0d_we", k), 32'(we), 32'(we6[k]));
        end
        req = '0; lock = '0;
        tick;
        tick;
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
